// File: rtl/brisc_multicycle_cpu.sv
// brisc_multicycle_cpu
//   Non-pipelined multi-cycle RV32I core. Each instruction walks through
//   IF, ID, EX, MEM and WB, one clock each, so it always takes 5 cycles.
//   The core owns its instruction memory, data memory and a 32x32 register
//   file. It has no external bus; state is observed hierarchically.
//
// Ports
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//
// Parameters
//   IMEM_WORDS / DMEM_WORDS : memory depths in 32-bit words (powers of two)
//   IMEM_INIT               : instruction memory image name
//   RESET_PC                : PC after reset
//
// Build option
//   MUL_EN : when defined, OP with funct7=0000001/funct3=000 executes MUL;
//            otherwise that encoding executes as a NOP.
//
// stage | meaning
// ------+---------------------------------------------
//   0   | IF  : fetch ir, next_pc = pc+4
//   1   | ID  : read A/B from regs, latch Imm
//   2   | EX  : ALU result, jump/branch target into next_pc
//   3   | MEM : LW latches LMD, SW writes dmem
//   4   | WB  : register write, pc = next_pc

module brisc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && rd != 5'd0) begin
      regs[rd] <= wd;
    end
  end

  assign rd1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
endmodule

module brisc_multicycle_cpu #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter string       IMEM_INIT  = "program.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2,
                            S_MEM = 3'd3, S_WB = 3'd4} stage_t;

  stage_t      stage, stage_nxt;
  logic [31:0] pc, ir, next_pc;
  logic [31:0] A, B, Imm, ALUOutput, LMD;
  logic [31:0] data_mem_out;
  logic        reg_w_en, mem_w_en;

  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] dmem [0:DMEM_WORDS-1];

  // Decode
  logic [6:0]  ir_op, ir_f7;
  logic [2:0]  ir_f3;
  logic [4:0]  ir_rs1, ir_rs2, ir_rd;
  logic [31:0] ir_imm;
  logic        ir_imm_j;

  assign ir_op    = ir[6:0];
  assign ir_rd    = ir[11:7];
  assign ir_f3    = ir[14:12];
  assign ir_rs1   = ir[19:15];
  assign ir_rs2   = ir[24:20];
  assign ir_f7    = ir[31:25];
  assign ir_imm_j = (ir_op == OP_JAL);

  always_comb begin
    ir_imm = '0;
    if (ir_imm_j)
      ir_imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    else case (ir_op)
      OP_LOAD, OP_IMM, OP_JALR: ir_imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:                 ir_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:                ir_imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         ir_imm = {ir[31:12], 12'd0};
      default:                  ir_imm = '0;
    endcase
  end

  // Instruction classes; anything not recognised here behaves as a NOP.
  logic op_ok, is_lw, is_sw, is_br, is_jalr, wr_rd;

  always_comb begin
    op_ok = 1'b0;
    if (ir_op == OP_OP) begin
      if (ir_f7 == 7'b0000000)
        op_ok = 1'b1;
      else if (ir_f7 == 7'b0100000 && (ir_f3 == 3'b000 || ir_f3 == 3'b101))
        op_ok = 1'b1;
`ifdef MUL_EN
      else if (ir_f7 == 7'b0000001 && ir_f3 == 3'b000)
        op_ok = 1'b1;
`endif
    end
  end

  assign is_lw   = (ir_op == OP_LOAD)  && (ir_f3 == 3'b010);
  assign is_sw   = (ir_op == OP_STORE) && (ir_f3 == 3'b010);
  assign is_jalr = (ir_op == OP_JALR)  && (ir_f3 == 3'b000);
  assign is_br   = (ir_op == OP_BRANCH) && (ir_f3[2:1] != 2'b01);
  assign wr_rd   = (ir_op == OP_LUI) || (ir_op == OP_AUIPC) || ir_imm_j ||
                   is_jalr || is_lw || (ir_op == OP_IMM) || op_ok;

  // Register file
  logic [31:0] rs1_data, rs2_data, wb_data;

  assign wb_data = is_lw ? LMD : (ir_imm_j || is_jalr) ? pc + 32'd4 : ALUOutput;

  brisc_regfile regs (
    .clk (clk),
    .rst (rst),
    .we  (reg_w_en),
    .rs1 (ir_rs1),
    .rs2 (ir_rs2),
    .rd  (ir_rd),
    .wd  (wb_data),
    .rd1 (rs1_data),
    .rd2 (rs2_data)
  );

  // ALU
  logic [31:0] alu_b, alu_res;
  logic [4:0]  shamt;
  logic        br_taken;

  assign alu_b = (ir_op == OP_OP) ? B : Imm;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = '0;
    case (ir_op)
      OP_LUI:            alu_res = Imm;
      OP_AUIPC, OP_JAL:  alu_res = pc + Imm;
      OP_JALR:           alu_res = (A + Imm) & ~32'd1;
      OP_LOAD, OP_STORE: alu_res = A + Imm;
      OP_IMM, OP_OP: begin
        case (ir_f3)
          3'b000: alu_res = (ir_op == OP_OP && ir_f7[5]) ? A - alu_b : A + alu_b;
          3'b001: alu_res = A << shamt;
          3'b010: alu_res = {31'd0, $signed(A) < $signed(alu_b)};
          3'b011: alu_res = {31'd0, A < alu_b};
          3'b100: alu_res = A ^ alu_b;
          3'b101: alu_res = ir_f7[5] ? 32'($signed(A) >>> shamt) : A >> shamt;
          3'b110: alu_res = A | alu_b;
          default: alu_res = A & alu_b;
        endcase
`ifdef MUL_EN
        if (ir_op == OP_OP && ir_f7 == 7'b0000001 && ir_f3 == 3'b000)
          alu_res = A * B;
`endif
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (ir_f3)
      3'b000: br_taken = (A == B);
      3'b001: br_taken = (A != B);
      3'b100: br_taken = ($signed(A) <  $signed(B));
      3'b101: br_taken = ($signed(A) >= $signed(B));
      3'b110: br_taken = (A <  B);
      3'b111: br_taken = (A >= B);
      default: br_taken = 1'b0;
    endcase
  end

  // Stage sequencer
  always_ff @(posedge clk) begin
    if (rst) stage <= S_IF;
    else     stage <= stage_nxt;
  end

  always_comb begin
    stage_nxt = S_IF;
    reg_w_en  = 1'b0;
    mem_w_en  = 1'b0;
    case (stage)
      S_IF:  stage_nxt = S_ID;
      S_ID:  stage_nxt = S_EX;
      S_EX:  stage_nxt = S_MEM;
      S_MEM: begin
        stage_nxt = S_WB;
        mem_w_en  = is_sw;
      end
      S_WB: begin
        stage_nxt = S_IF;
        reg_w_en  = wr_rd && (ir_rd != 5'd0);
      end
      default: stage_nxt = S_IF;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= NOP;
      next_pc   <= RESET_PC;
      A         <= '0;
      B         <= '0;
      Imm       <= '0;
      ALUOutput <= '0;
      LMD       <= '0;
    end else begin
      case (stage)
        S_IF: begin
          ir      <= imem[pc[IA+1:2]];
          next_pc <= pc + 32'd4;
        end
        S_ID: begin
          A   <= rs1_data;
          B   <= rs2_data;
          Imm <= ir_imm;
        end
        S_EX: begin
          ALUOutput <= alu_res;
          if (ir_imm_j || is_jalr)     next_pc <= alu_res;
          else if (is_br && br_taken)  next_pc <= pc + Imm;
        end
        S_MEM: if (is_lw) LMD <= data_mem_out;
        S_WB:  pc <= next_pc;
        default: ;
      endcase
    end
  end

  // Data memory: word access, low address bits ignored, index wraps.
  assign data_mem_out = dmem[ALUOutput[DA+1:2]];

  always_ff @(posedge clk) begin
    if (!rst && mem_w_en) dmem[ALUOutput[DA+1:2]] <= B;
  end
endmodule

// File: tb/tb_brisc_multicycle_cpu.sv
module tb_brisc_multicycle_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  brisc_multicycle_cpu #(
    .IMEM_WORDS (1024),
    .DMEM_WORDS (1024),
    .IMEM_INIT  (""),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: stage sequence and write-enable timing.
  task automatic run_instr(input string tag, input logic exp_rwe, input logic exp_mwe);
    for (int s = 0; s < 5; s++) begin
      check({tag, " stage"}, 32'(dut.stage), 32'(s));
      check({tag, " reg_w_en"}, 32'(dut.reg_w_en), 32'(exp_rwe && s == 4));
      check({tag, " mem_w_en"}, 32'(dut.mem_w_en), 32'(exp_mwe && s == 3));
      tick();
    end
  endtask

  logic [31:0] mul_exp;
  logic        mul_we;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0000_0013;
    dut.imem[0]  = 32'h0050_0093; // 00 addi x1,x0,5
    dut.imem[1]  = 32'hFFD0_0113; // 04 addi x2,x0,-3
    dut.imem[2]  = 32'h0020_81B3; // 08 add  x3,x1,x2
    dut.imem[3]  = 32'h4020_8233; // 0C sub  x4,x1,x2
    dut.imem[4]  = 32'h0010_8663; // 10 beq  x1,x1,+12
    dut.imem[5]  = 32'h0010_0513; // 14 addi x10,x0,1 (skipped)
    dut.imem[6]  = 32'h0010_0513; // 18 addi x10,x0,1 (skipped)
    dut.imem[7]  = 32'h0010_9663; // 1C bne  x1,x1,+12 (not taken)
    dut.imem[8]  = 32'h0100_03EF; // 20 jal  x7,+16
    dut.imem[9]  = 32'h0010_0513; // 24 skipped
    dut.imem[10] = 32'h0010_0513; // 28 skipped
    dut.imem[11] = 32'h0010_0513; // 2C skipped
    dut.imem[12] = 32'h4011_5293; // 30 srai x5,x2,1
    dut.imem[13] = 32'h0010_2423; // 34 sw   x1,8(x0)
    dut.imem[14] = 32'h0080_2303; // 38 lw   x6,8(x0)
    dut.imem[15] = 32'h0070_0013; // 3C addi x0,x0,7
    dut.imem[16] = 32'h0000_0073; // 40 ecall (nop)
    dut.imem[17] = 32'h0220_84B3; // 44 mul  x9,x1,x2
    dut.imem[18] = 32'h0090_0413; // 48 addi x8,x0,9

`ifdef MUL_EN
    mul_exp = 32'hFFFF_FFF1;
    mul_we  = 1'b1;
`else
    mul_exp = 32'h0000_0000;
    mul_we  = 1'b0;
`endif

    rst = 1'b1;
    tick();
    tick();
    check("rst stage", 32'(dut.stage), 32'd0);
    check("rst pc", dut.pc, 32'h0);
    check("rst ir", dut.ir, 32'h0000_0013);
    check("rst next_pc", dut.next_pc, 32'h0);
    check("rst A", dut.A, 32'h0);
    check("rst ALUOutput", dut.ALUOutput, 32'h0);
    check("rst x1", dut.regs.regs[1], 32'h0);
    rst = 1'b0;

    run_instr("addi x1", 1'b1, 1'b0);
    check("x1", dut.regs.regs[1], 32'h0000_0005);
    check("pc after addi", dut.pc, 32'h0000_0004);

    run_instr("addi x2", 1'b1, 1'b0);
    check("x2", dut.regs.regs[2], 32'hFFFF_FFFD);
    run_instr("add", 1'b1, 1'b0);
    check("x3", dut.regs.regs[3], 32'h0000_0002);
    run_instr("sub", 1'b1, 1'b0);
    check("x4", dut.regs.regs[4], 32'h0000_0008);

    run_instr("beq", 1'b0, 1'b0);
    check("pc after beq", dut.pc, 32'h0000_001C);
    run_instr("bne", 1'b0, 1'b0);
    check("pc after bne", dut.pc, 32'h0000_0020);

    run_instr("jal", 1'b1, 1'b0);
    check("x7 link", dut.regs.regs[7], 32'h0000_0024);
    check("pc after jal", dut.pc, 32'h0000_0030);
    check("x10 untouched", dut.regs.regs[10], 32'h0);

    run_instr("srai", 1'b1, 1'b0);
    check("x5", dut.regs.regs[5], 32'hFFFF_FFFE);

    run_instr("sw", 1'b0, 1'b1);
    check("dmem[2]", dut.dmem[2], 32'h0000_0005);
    run_instr("lw", 1'b1, 1'b0);
    check("x6", dut.regs.regs[6], 32'h0000_0005);
    check("LMD", dut.LMD, 32'h0000_0005);

    run_instr("addi x0", 1'b0, 1'b0);
    check("x0", dut.regs.regs[0], 32'h0);
    run_instr("ecall", 1'b0, 1'b0);
    check("pc after ecall", dut.pc, 32'h0000_0044);

    run_instr("mul", mul_we, 1'b0);
    check("x9 mul", dut.regs.regs[9], mul_exp);
    check("pc after mul", dut.pc, 32'h0000_0048);

    // Reset while addi x8 sits in EX.
    tick();
    tick();
    check("pre-rst stage EX", 32'(dut.stage), 32'd2);
    rst = 1'b1;
    tick();
    check("mid rst stage", 32'(dut.stage), 32'd0);
    check("mid rst pc", dut.pc, 32'h0);
    check("mid rst next_pc", dut.next_pc, 32'h0);
    check("mid rst x8", dut.regs.regs[8], 32'h0);
    check("mid rst x1 cleared", dut.regs.regs[1], 32'h0);
    check("dmem kept", dut.dmem[2], 32'h0000_0005);
    rst = 1'b0;

    run_instr("addi x1 again", 1'b1, 1'b0);
    check("x1 again", dut.regs.regs[1], 32'h0000_0005);
    check("pc again", dut.pc, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
